universal_shift_reg: RTL and testbench

Parametrised universal shift register with parallel load, four shift modes and a frame counter. It replaces the fixed right-shift parallel-load register in serial-link and bit-serial datapaths. After every parallel load it counts shifts and flags completion of a full word, so a controller can serialise words without its own bit counter.

---
 rtl/universal_shift_reg_pkg.sv | 17 +
 rtl/universal_shift_reg_if.sv | 32 +++
 rtl/universal_shift_reg.sv | 73 +++++++
 tb/tb_universal_shift_reg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/universal_shift_reg_pkg.sv
// Shared encodings for the universal shift register: shift modes and
// frame-tracking states.
package universal_shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SR   = 2'b01,
    MODE_SL   = 2'b10,
    MODE_ROR  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for the universal shift register; clock and reset stay
// outside as plain ports.
interface universal_shift_reg_if
  import universal_shift_reg_pkg::*;
#(
  parameter int BITS = 8
);
  // Strobe semantics, no valid/ready: Load and En are sampled on every rising
  // edge with no backpressure; Done is a one-cycle pulse and Busy a level,
  // both registered.
  logic [BITS-1:0] data;
  logic            Load;
  logic [1:0]      Mode;
  logic            En;
  logic            In;
  logic [BITS-1:0] Q;
  logic            SO;
  logic            Busy;
  logic            Done;
  state_e          dbg_state;

  modport master (
    output data, Load, Mode, En, In,
    input  Q, SO, Busy, Done, dbg_state
  );

  modport slave (
    input  data, Load, Mode, En, In,
    output Q, SO, Busy, Done, dbg_state
  );

endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, four shift modes and a frame
// counter that pulses Done after BITS shift steps following a Load.
module universal_shift_reg
  import universal_shift_reg_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int CNT_W = $clog2(BITS)
) (
  input logic                  CLK,
  input logic                  RST,
  universal_shift_reg_if.slave bus
);

  logic [BITS-1:0]  q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             shift_step;
  mode_e            mode;

  assign mode       = mode_e'(bus.Mode);
  assign shift_step = bus.En && (mode != MODE_HOLD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q     <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (bus.Load) begin
      q_d     = bus.data;
      cnt_d   = '0;
      state_d = ST_BUSY;
    end else if (shift_step) begin
      case (mode)
        MODE_SR:  q_d = {bus.In, q_q[BITS-1:1]};
        MODE_SL:  q_d = {q_q[BITS-2:0], bus.In};
        MODE_ROR: q_d = {q_q[0], q_q[BITS-1:1]};
        default:  q_d = q_q;
      endcase
      // Outside a frame the data still shifts but the counter stays frozen.
      if (state_q == ST_BUSY) begin
        if (cnt_q == CNT_W'(BITS - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.Q         = q_q;
  assign bus.SO        = (mode == MODE_SL) ? q_q[BITS-1] : q_q[0];
  assign bus.Busy      = (state_q == ST_BUSY);
  assign bus.Done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed frame scenarios and a randomized
// phase, all checked against a behavioural word-level model.
module tb_universal_shift_reg;
  import universal_shift_reg_pkg::*;

  localparam int BITS = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  universal_shift_reg_if #(.BITS(BITS)) bus ();

  universal_shift_reg #(.BITS(BITS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: word value, shifts since load, frame flag, done pulse
  logic [BITS-1:0] m_q;
  int              m_shifts;
  bit              m_busy;
  bit              m_done;

  task automatic model_edge(input logic r, input logic l, input logic [BITS-1:0] d,
                            input logic [1:0] m, input logic e, input logic i);
    m_done = 0;
    if (r) begin
      m_q = '0; m_shifts = 0; m_busy = 0;
    end else if (l) begin
      m_q = d; m_shifts = 0; m_busy = 1;
    end else if (e && m != 2'd0) begin
      if (m == 2'd1)      m_q = (m_q >> 1) | (BITS'(i) << (BITS - 1));
      else if (m == 2'd2) m_q = BITS'((m_q << 1) | BITS'(i));
      else                m_q = (m_q >> 1) | (BITS'(m_q[0]) << (BITS - 1));
      if (m_busy) begin
        m_shifts++;
        if (m_shifts == BITS) begin
          m_busy = 0; m_shifts = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic exp_so;
    exp_so = (bus.Mode == 2'd2) ? m_q[BITS-1] : m_q[0];
    check("q",     32'(bus.Q),    32'(m_q));
    check("so",    32'(bus.SO),   32'(exp_so));
    check("busy",  32'(bus.Busy), 32'(m_busy));
    check("done",  32'(bus.Done), 32'(m_done));
    check("state", 32'(bus.dbg_state == ST_BUSY), 32'(m_busy));
  endtask

  // driver: apply inputs, take one edge, update model, sample 1ns later
  task automatic step(input logic r, input logic l, input logic [BITS-1:0] d,
                      input logic [1:0] m, input logic e, input logic i);
    rst = r; bus.Load = l; bus.data = d; bus.Mode = m; bus.En = e; bus.In = i;
    @(posedge clk);
    model_edge(r, l, d, m, e, i);
    #1;
    check_model();
  endtask

  task automatic shift(input logic [1:0] m, input logic i);
    step(1'b0, 1'b0, '0, m, 1'b1, i);
  endtask

  task automatic load(input logic [BITS-1:0] d, input logic [1:0] m);
    step(1'b0, 1'b1, d, m, 1'b0, 1'b0);
  endtask

  initial begin
    logic [BITS-1:0] rs_q [8];
    logic            rs_so [8];
    n_cmp = 0; n_fail = 0;
    m_q = '0; m_shifts = 0; m_busy = 0; m_done = 0;
    rs_q  = '{8'h85, 8'hC2, 8'hE1, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    rs_so = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; bus.Load = 0; bus.data = '0; bus.Mode = 2'd0; bus.En = 0; bus.In = 0;

    // reset: two cycles asserted, then release
    step(1'b1, 1'b0, '0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 2'd0, 1'b0, 1'b0);
    check("rst_q", 32'(bus.Q), 32'h0);
    check("rst_busy_done", 32'({bus.SO, bus.Busy, bus.Done}), 32'h0);

    // right-shift frame from 0x0A with In=1
    load(8'h0A, 2'd1);
    check("rs_so0", 32'(bus.SO), 32'(rs_so[0]));
    for (int k = 0; k < 8; k++) begin
      shift(2'd1, 1'b1);
      check("rs_q", 32'(bus.Q), 32'(rs_q[k]));
      if (k < 7) check("rs_so", 32'(bus.SO), 32'(rs_so[k+1]));
      check("rs_done", 32'(bus.Done), 32'(k == 7));
      check("rs_busy", 32'(bus.Busy), 32'(k != 7));
    end
    step(1'b0, 1'b0, '0, 2'd1, 1'b0, 1'b0);
    check("rs_done_once", 32'(bus.Done), 32'h0);

    // left shift from 0x81 with In=0
    load(8'h81, 2'd2);
    check("sl_so0", 32'(bus.SO), 32'h1);
    shift(2'd2, 1'b0);
    check("sl_q1", 32'(bus.Q), 32'h02);
    shift(2'd2, 1'b0);
    check("sl_q2", 32'(bus.Q), 32'h04);
    for (int k = 2; k < 8; k++) shift(2'd2, 1'b0);
    check("sl_q8", 32'(bus.Q), 32'h00);
    check("sl_done", 32'(bus.Done), 32'h1);

    // rotate right from 0x01, In ignored
    load(8'h01, 2'd3);
    shift(2'd3, 1'b1);
    check("ror_q1", 32'(bus.Q), 32'h80);
    for (int k = 1; k < 8; k++) shift(2'd3, 1'b1);
    check("ror_q8", 32'(bus.Q), 32'h01);
    check("ror_done", 32'(bus.Done), 32'h1);

    // stall mid-frame: En low 3 cycles, Mode=00 for 2 cycles
    load(8'hA5, 2'd1);
    for (int k = 0; k < 4; k++) shift(2'd1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 2'd1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b1);
    check("stall_q", 32'(bus.Q), 32'h0A);
    check("stall_busy", 32'(bus.Busy), 32'h1);
    for (int k = 0; k < 3; k++) shift(2'd2, 1'b1);
    check("stall_no_done", 32'(bus.Done), 32'h0);
    shift(2'd3, 1'b0);
    check("stall_done", 32'(bus.Done), 32'h1);

    // reload after 6 shifts: new frame needs 8 more
    load(8'hF0, 2'd1);
    for (int k = 0; k < 6; k++) shift(2'd1, 1'b0);
    load(8'h55, 2'd1);
    check("pre_load_q", 32'(bus.Q), 32'h55);
    for (int k = 0; k < 7; k++) shift(2'd1, 1'b1);
    check("pre_load_no_done", 32'(bus.Done), 32'h0);
    shift(2'd1, 1'b1);
    check("pre_load_done", 32'(bus.Done), 32'h1);

    // reset after 3 shifts aborts the frame
    load(8'h3C, 2'd2);
    for (int k = 0; k < 3; k++) shift(2'd2, 1'b1);
    step(1'b1, 1'b0, '0, 2'd2, 1'b1, 1'b1);
    check("pre_rst_q", 32'(bus.Q), 32'h0);
    check("pre_rst_flags", 32'({bus.SO, bus.Busy, bus.Done}), 32'h0);

    // load coincident with the frame-completing edge
    load(8'hC3, 2'd1);
    for (int k = 0; k < 7; k++) shift(2'd1, 1'b0);
    step(1'b0, 1'b1, 8'h99, 2'd1, 1'b1, 1'b0);
    check("pre_lc_done", 32'(bus.Done), 32'h0);
    check("pre_lc_q", 32'(bus.Q), 32'h99);
    check("pre_lc_busy", 32'(bus.Busy), 32'h1);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
           BITS'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
